// File: rtl/demux_if.sv
// Registered 1-to-2 demultiplexer: routes a captured data word to one of two
// destinations with a one-cycle valid pulse; the unselected destination is zeroed.
module demux_if #(
    parameter int width = 8,
    parameter int snum  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i,
    input  logic [snum-1:0]  sel,
    input  logic             en,
    output logic [width-1:0] o0,
    output logic [width-1:0] o1,
    output logic             v0,
    output logic             v1
);

    localparam logic [snum-1:0]  sel_zero  = {snum{1'b0}};
    localparam logic [snum-1:0]  sel_one   = snum'(1);
    localparam logic [width-1:0] data_zero = {width{1'b0}};

    logic [width-1:0] o0_r, o1_r;
    logic             v0_r, v1_r;
    logic [width-1:0] o0_s, o1_s;
    logic             v0_s, v1_s;

    // Next-state routing; out-of-range selects drop the sample and zero both sides.
    always_comb begin
        o0_s = o0_r;
        o1_s = o1_r;
        v0_s = 1'b0;
        v1_s = 1'b0;
        if (en) begin
            if (sel == sel_zero) begin
                o0_s = i;
                o1_s = data_zero;
                v0_s = 1'b1;
            end else if (sel == sel_one) begin
                o0_s = data_zero;
                o1_s = i;
                v1_s = 1'b1;
            end else begin
                o0_s = data_zero;
                o1_s = data_zero;
            end
        end else begin
            o0_s = o0_r;
            o1_s = o1_r;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o0_r <= data_zero;
            o1_r <= data_zero;
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else begin
            o0_r <= o0_s;
            o1_r <= o1_s;
            v0_r <= v0_s;
            v1_r <= v1_s;
        end
    end

    assign o0 = o0_r;
    assign o1 = o1_r;
    assign v0 = v0_r;
    assign v1 = v1_r;

endmodule

// File: tb/tb_demux_if.sv
// Bench for demux_if: one snum=1 and one snum=2 instance share stimulus; a
// reference model feeds a scoreboard queue and a hand-written vector table.
module tb_demux_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i   = 8'h00;
    logic       sel1 = 1'b0;
    logic [1:0] sel2 = 2'd0;
    logic       en  = 1'b0;

    logic [7:0] a_o0, a_o1, b_o0, b_o1;
    logic       a_v0, a_v1, b_v0, b_v1;

    always #5 clk = ~clk;

    demux_if #(.width(8), .snum(1)) dut_a (
        .clk(clk), .rst(rst), .i(i), .sel(sel1), .en(en),
        .o0(a_o0), .o1(a_o1), .v0(a_v0), .v1(a_v1)
    );

    demux_if #(.width(8), .snum(2)) dut_b (
        .clk(clk), .rst(rst), .i(i), .sel(sel2), .en(en),
        .o0(b_o0), .o1(b_o1), .v0(b_v0), .v1(b_v1)
    );

    typedef struct packed {
        logic [7:0] o0;
        logic [7:0] o1;
        logic       v0;
        logic       v1;
    } out_t;

    typedef struct {
        out_t a;
        out_t b;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        logic       e;
        out_t       exp_b;
    } vec_t;

    exp_t sb[$];
    out_t ma = '0;
    out_t mb = '0;
    vec_t tbl[10];
    int   checks   = 0;
    int   failures = 0;

    function automatic out_t model(out_t cur, logic [7:0] d, int s, logic e);
        out_t n = cur;
        n.v0 = 1'b0;
        n.v1 = 1'b0;
        if (e) begin
            n.o0 = 8'h00;
            n.o1 = 8'h00;
            if (s == 0) begin
                n.o0 = d;
                n.v0 = 1'b1;
            end else if (s == 1) begin
                n.o1 = d;
                n.v1 = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input out_t act, input out_t exp);
        check({tag, ".o0"}, act.o0, exp.o0);
        check({tag, ".o1"}, act.o1, exp.o1);
        check({tag, ".v0"}, {7'd0, act.v0}, {7'd0, exp.v0});
        check({tag, ".v1"}, {7'd0, act.v1}, {7'd0, exp.v1});
    endtask

    function automatic out_t act_a();
        return {a_o0, a_o1, a_v0, a_v1};
    endfunction

    function automatic out_t act_b();
        return {b_o0, b_o1, b_v0, b_v1};
    endfunction

    // Drive one sample, push model expectations, then pop and compare after the edge.
    task automatic step(input string tag, input logic [7:0] d, input logic [1:0] s, input logic e);
        exp_t x;
        i    = d;
        sel2 = s;
        sel1 = s[0];
        en   = e;
        ma   = model(ma, d, int'(s[0]), e);
        mb   = model(mb, d, int'(s), e);
        x.a  = ma;
        x.b  = mb;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_out({tag, ".a"}, act_a(), x.a);
        check_out({tag, ".b"}, act_b(), x.b);
        check({tag, ".exclusive_a"}, {7'd0, a_v0 & a_v1}, 8'h00);
        check({tag, ".exclusive_b"}, {7'd0, b_v0 & b_v1}, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hA0, 2'd0, 1'b1, {8'hA0, 8'h00, 1'b1, 1'b0}};
        tbl[1] = '{8'hB0, 2'd1, 1'b1, {8'h00, 8'hB0, 1'b0, 1'b1}};
        tbl[2] = '{8'hFF, 2'd0, 1'b0, {8'h00, 8'hB0, 1'b0, 1'b0}};
        tbl[3] = '{8'h11, 2'd0, 1'b1, {8'h11, 8'h00, 1'b1, 1'b0}};
        tbl[4] = '{8'h3C, 2'd2, 1'b1, {8'h00, 8'h00, 1'b0, 1'b0}};
        tbl[5] = '{8'h22, 2'd3, 1'b0, {8'h00, 8'h00, 1'b0, 1'b0}};
        tbl[6] = '{8'h80, 2'd1, 1'b1, {8'h00, 8'h80, 1'b0, 1'b1}};
        tbl[7] = '{8'h7F, 2'd1, 1'b1, {8'h00, 8'h7F, 1'b0, 1'b1}};
        tbl[8] = '{8'h01, 2'd0, 1'b1, {8'h01, 8'h00, 1'b1, 1'b0}};
        tbl[9] = '{8'h55, 2'd3, 1'b1, {8'h00, 8'h00, 1'b0, 1'b0}};

        // Reset state, with enable high to show edges are ignored.
        en = 1'b1;
        i  = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset.a", act_a(), '0);
        check_out("reset.b", act_b(), '0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            step($sformatf("vec%0d", k), tbl[k].d, tbl[k].s, tbl[k].e);
            check_out($sformatf("vec%0d.tbl", k), act_b(), tbl[k].exp_b);
        end

        // Alternating select, back-to-back, incrementing data.
        for (int k = 0; k < 8; k++) begin
            step($sformatf("alt%0d", k), 8'h40 + 8'(k), 2'(k % 2), 1'b1);
            check($sformatf("alt%0d.word", k), (k % 2 == 0) ? b_o0 : b_o1, 8'h40 + 8'(k));
            check($sformatf("alt%0d.other", k), (k % 2 == 0) ? b_o1 : b_o0, 8'h00);
        end

        // Mid-stream asynchronous reset, then edges ignored while held.
        step("pre_rst", 8'h5A, 2'd0, 1'b1);
        check("pre_rst.o0", a_o0, 8'h5A);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst.a", act_a(), '0);
        check_out("async_rst.b", act_b(), '0);
        i    = 8'hFF;
        sel1 = 1'b1;
        sel2 = 2'd1;
        en   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("rst_hold%0d.a", k), act_a(), '0);
            check_out($sformatf("rst_hold%0d.b", k), act_b(), '0);
        end
        @(negedge clk);
        rst = 1'b0;
        ma  = '0;
        mb  = '0;
        step("post_rst", 8'hC3, 2'd1, 1'b1);
        check("post_rst.o1", b_o1, 8'hC3);
        step("post_idle", 8'h00, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_if.md
DEMUX_IF -- requirements
Module: demux_if

Interface
REQ-001 Parameter width, default 8: data path width in bits; legal range 1 and up.
REQ-002 Parameter snum, default 1: select width in bits; legal range 1 and up.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i  input  width  data word to be routed.
REQ-007 sel  input  snum  destination select.
REQ-008 en  input  1  capture enable; when high, the sample is routed on this edge.
REQ-009 o0  output  width  registered destination 0 data.
REQ-010 o1  output  width  registered destination 1 data.
REQ-011 v0  output  1  registered destination 0 valid pulse.
REQ-012 v1  output  1  registered destination 1 valid pulse.

Function
REQ-013 All outputs SHALL be driven directly from flip-flops; there is no combinational path from any input to any output.
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N appear on the outputs after edge N.
REQ-015 At an edge with en=1 and sel==0: o0<=i, o1<=0, v0<=1, v1<=0.
REQ-016 At an edge with en=1 and sel==1: o1<=i, o0<=0, v1<=1, v0<=0.
REQ-017 At an edge with en=1 and sel>=2 (possible only when snum>1): o0<=0, o1<=0, v0<=0, v1<=0; the sample is dropped.
REQ-018 The unselected output SHALL always be forced to all-zeros, never left holding a prior value, on any en=1 edge.
REQ-019 At an edge with en=0: o0 and o1 hold their values; v0 and v1 clear to 0.
REQ-020 v0 and v1 SHALL never be 1 simultaneously.
REQ-021 Back-to-back en=1 edges SHALL each be routed independently with no bubble; a select change between consecutive edges takes effect on the next edge.
REQ-022 Data SHALL pass bit-exact with no sign extension, truncation or inversion for any width.

Reset
REQ-023 While rst=1: o0=0, o1=0, v0=0, v1=0.
REQ-024 Reset assertion SHALL clear the outputs immediately, without waiting for a clock edge, including mid-stream between edges.
REQ-025 While rst=1, edges SHALL be ignored regardless of en, sel or i.
REQ-026 The first capture after reset SHALL occur at the first rising edge at which rst is low and en=1.

Verification
REQ-027 width=8, snum=1: reset, then i=0xA0, sel=0, en=1, one edge -> o0=0xA0, o1=0x00, v0=1, v1=0.
REQ-028 Next edge with i=0xB0, sel=1, en=1 -> o0=0x00, o1=0xB0, v0=0, v1=1.
REQ-029 Next edge with en=0, i=0xFF -> o1 stays 0xB0, o0 stays 0x00, v0=0, v1=0.
REQ-030 Set o0=0x5A, v0=1, then assert rst between edges -> all outputs are 0 before the next edge; they stay 0 through two edges with en=1 while rst=1.
REQ-031 snum=2: i=0x3C, sel=2, en=1 after o0 holds 0x11 -> o0=0, o1=0, v0=0, v1=0.
REQ-032 Alternate sel 0/1 on every edge with en=1 and an incrementing i -> each output carries its word one cycle later, zero on the other cycles, and v0/v1 alternate.
